// File: rtl/control_pipe.sv
// Carries decoder control bundles through the EX, MEM and WB stage registers, inserting bubbles for stalls, flushes and illegal decodes.
// Optional feature: define ILLEGAL_TRAP_EN to enable the illegalOp pulse and the sticky illegalSeen flag.
module control_pipe #(
  parameter int WB_W   = 2,
  parameter int MEM_W  = 3,
  parameter int CALC_W = 4,
  parameter int OP_MAX = 3
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              idValid,
  input  logic [5:0]        opCode,
  input  logic [WB_W-1:0]   writeBackControl,
  input  logic [MEM_W-1:0]  memAccessControl,
  input  logic [CALC_W-1:0] calculationControl,
  input  logic              stall,
  input  logic              flush,
  output logic              exValid,
  output logic              memValid,
  output logic              wbValid,
  output logic [CALC_W-1:0] exCalc,
  output logic              exMemRead,
  output logic [MEM_W-1:0]  memAccess,
  output logic [WB_W-1:0]   wbControl,
  output logic              illegalOp,
  output logic              illegalSeen
);

  localparam logic [5:0] OP_LIMIT = 6'(OP_MAX);

  typedef enum logic [1:0] {
    MODE_NORMAL,
    MODE_STALL,
    MODE_FLUSH
  } mode_t;

  mode_t             mode;
  logic              legal;
  logic [WB_W-1:0]   dec_wb;
  logic [MEM_W-1:0]  dec_mem;
  logic [CALC_W-1:0] dec_calc;

  logic              ex_valid;
  logic [WB_W-1:0]   ex_wb;
  logic [MEM_W-1:0]  ex_mem;
  logic [CALC_W-1:0] ex_calc;
  logic              mem_valid;
  logic [WB_W-1:0]   mem_wb;
  logic [MEM_W-1:0]  mem_mem;
  logic              wb_valid;
  logic [WB_W-1:0]   wb_wb;

  // Flush outranks stall: the squashed younger ops make the stall moot.
  always_comb begin
    mode = MODE_NORMAL;
    if (flush)
      mode = MODE_FLUSH;
    else if (stall)
      mode = MODE_STALL;
  end

  assign legal = idValid && (opCode <= OP_LIMIT);

  // Without regWrite, memToReg and regDst are don't-cares from the decoder; pin them to 0.
  always_comb begin
    dec_wb   = '0;
    dec_mem  = '0;
    dec_calc = '0;
    if (legal) begin
      dec_wb   = writeBackControl;
      dec_mem  = memAccessControl;
      dec_calc = calculationControl;
      if (writeBackControl[WB_W-1] != 1'b1) begin
        dec_wb[0]          = 1'b0;
        dec_calc[CALC_W-1] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      ex_valid  <= 1'b0;
      ex_wb     <= '0;
      ex_mem    <= '0;
      ex_calc   <= '0;
      mem_valid <= 1'b0;
      mem_wb    <= '0;
      mem_mem   <= '0;
      wb_valid  <= 1'b0;
      wb_wb     <= '0;
    end else begin
      wb_valid <= mem_valid;
      wb_wb    <= mem_wb;
      case (mode)
        MODE_FLUSH: begin
          ex_valid  <= 1'b0;
          ex_wb     <= '0;
          ex_mem    <= '0;
          ex_calc   <= '0;
          mem_valid <= 1'b0;
          mem_wb    <= '0;
          mem_mem   <= '0;
        end
        MODE_STALL: begin
          ex_valid  <= 1'b0;
          ex_wb     <= '0;
          ex_mem    <= '0;
          ex_calc   <= '0;
          mem_valid <= ex_valid;
          mem_wb    <= ex_wb;
          mem_mem   <= ex_mem;
        end
        default: begin
          ex_valid  <= legal;
          ex_wb     <= dec_wb;
          ex_mem    <= dec_mem;
          ex_calc   <= dec_calc;
          mem_valid <= ex_valid;
          mem_wb    <= ex_wb;
          mem_mem   <= ex_mem;
        end
      endcase
    end
  end

  assign exValid   = ex_valid;
  assign exCalc    = ex_calc;
  assign exMemRead = ex_valid & ex_mem[1];
  assign memValid  = mem_valid;
  assign memAccess = mem_mem;
  assign wbValid   = wb_valid;
  assign wbControl = wb_wb;

`ifdef ILLEGAL_TRAP_EN
  logic ill_q;
  logic seen_q;
  logic ill_take;

  assign ill_take = (mode == MODE_NORMAL) && idValid && (opCode > OP_LIMIT);

  always_ff @(posedge clk) begin
    if (!resetN) begin
      ill_q  <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      ill_q <= ill_take;
      if (ill_take)
        seen_q <= 1'b1;
    end
  end

  assign illegalOp   = ill_q;
  assign illegalSeen = seen_q;
`else
  assign illegalOp   = 1'b0;
  assign illegalSeen = 1'b0;
`endif

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe: reset, LW/SW latency, illegal sanitising, stall bubble, flush, stall+flush, mid-stream reset.
module tb_control_pipe;

`ifdef ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetN;
  logic       idValid;
  logic [5:0] opCode;
  logic [1:0] writeBackControl;
  logic [2:0] memAccessControl;
  logic [3:0] calculationControl;
  logic       stall;
  logic       flush;
  logic       exValid, memValid, wbValid, exMemRead, illegalOp, illegalSeen;
  logic [3:0] exCalc;
  logic [2:0] memAccess;
  logic [1:0] wbControl;

  int total = 0;
  int bad   = 0;

  control_pipe #(.WB_W(2), .MEM_W(3), .CALC_W(4), .OP_MAX(3)) dut (
    .clk(clk), .resetN(resetN), .idValid(idValid), .opCode(opCode),
    .writeBackControl(writeBackControl), .memAccessControl(memAccessControl),
    .calculationControl(calculationControl), .stall(stall), .flush(flush),
    .exValid(exValid), .memValid(memValid), .wbValid(wbValid), .exCalc(exCalc),
    .exMemRead(exMemRead), .memAccess(memAccess), .wbControl(wbControl),
    .illegalOp(illegalOp), .illegalSeen(illegalSeen)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic exv, input logic [3:0] exc, input logic exmr,
                         input logic memv, input logic [2:0] mema, input logic wbv, input logic [1:0] wbc);
    chk({tag, ".exValid"},   8'(exValid),   8'(exv));
    chk({tag, ".exCalc"},    8'(exCalc),    8'(exc));
    chk({tag, ".exMemRead"}, 8'(exMemRead), 8'(exmr));
    chk({tag, ".memValid"},  8'(memValid),  8'(memv));
    chk({tag, ".memAccess"}, 8'(memAccess), 8'(mema));
    chk({tag, ".wbValid"},   8'(wbValid),   8'(wbv));
    chk({tag, ".wbControl"}, 8'(wbControl), 8'(wbc));
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [1:0] wb,
                       input logic [2:0] mem, input logic [3:0] calc);
    idValid            = v;
    opCode             = op;
    writeBackControl   = wb;
    memAccessControl   = mem;
    calculationControl = calc;
  endtask

  // Decoder encodings: R(0), LW(1), SW(2), BEQ(3); SW/BEQ carry x don't-cares.
  task automatic drv_r();   drive(1'b1, 6'd0, 2'b10, 3'b000, 4'b1100); endtask
  task automatic drv_lw();  drive(1'b1, 6'd1, 2'b11, 3'b010, 4'b0001); endtask
  task automatic drv_sw();  drive(1'b1, 6'd2, 2'b0x, 3'b001, 4'bx001); endtask
  task automatic drv_beq(); drive(1'b1, 6'd3, 2'b0x, 3'b100, 4'bx010); endtask
  task automatic drv_idle(); drive(1'b0, 6'd0, 2'b00, 3'b000, 4'b0000); endtask

  initial begin
    // 1: reset with a live R-type at decode
    resetN = 1'b0; stall = 1'b0; flush = 1'b0;
    drv_r();
    tick(); tick();
    chk_all("reset", 0, 4'h0, 0, 0, 3'h0, 0, 2'h0);
    chk("reset.illegalOp",   8'(illegalOp),   8'h0);
    chk("reset.illegalSeen", 8'(illegalSeen), 8'h0);
    resetN = 1'b1;
    drv_idle();
    tick();
    chk_all("idle", 0, 4'h0, 0, 0, 3'h0, 0, 2'h0);

    // 2: LW latency through EX, MEM, WB
    drv_lw();   tick(); chk_all("lw.ex",  1, 4'b0001, 1, 0, 3'h0,   0, 2'h0);
    drv_idle(); tick(); chk_all("lw.mem", 0, 4'h0,    0, 1, 3'b010, 0, 2'h0);
    tick();             chk_all("lw.wb",  0, 4'h0,    0, 0, 3'h0,   1, 2'b11);
    tick();             chk_all("lw.out", 0, 4'h0,    0, 0, 3'h0,   0, 2'h0);

    // SW: x don't-cares land as 0
    drv_sw();   tick(); chk_all("sw.ex",  1, 4'b0001, 0, 0, 3'h0,   0, 2'h0);
    drv_idle(); tick(); chk_all("sw.mem", 0, 4'h0,    0, 1, 3'b001, 0, 2'h0);
    tick();             chk_all("sw.wb",  0, 4'h0,    0, 0, 3'h0,   1, 2'b00);

    // 3: illegal op 5 with x bundles, then op 4 (one past OP_MAX), then idValid=0
    drive(1'b1, 6'd5, 2'bxx, 3'bxxx, 4'bxxxx);
    tick();
    chk_all("ill5", 0, 4'h0, 0, 0, 3'h0, 0, 2'h0);
    chk("ill5.illegalOp",   8'(illegalOp),   8'(TRAP));
    chk("ill5.illegalSeen", 8'(illegalSeen), 8'(TRAP));
    drv_idle();
    tick();
    chk("ill5.pulse_end", 8'(illegalOp),   8'h0);
    chk("ill5.sticky",    8'(illegalSeen), 8'(TRAP));
    drive(1'b1, 6'd4, 2'b11, 3'b010, 4'b0001);
    tick();
    chk_all("ill4", 0, 4'h0, 0, 0, 3'h0, 0, 2'h0);
    drive(1'b0, 6'd1, 2'b11, 3'b010, 4'b0001);
    tick();
    chk_all("inval", 0, 4'h0, 0, 0, 3'h0, 0, 2'h0);
    chk("inval.illegalOp", 8'(illegalOp), 8'h0);

    // 4: LW then R with a one-cycle load-use stall
    drv_lw(); tick();
    chk_all("st.lw_ex", 1, 4'b0001, 1, 0, 3'h0, 0, 2'h0);
    drv_r(); stall = 1'b1;
    tick();
    chk_all("st.bubble", 0, 4'h0, 0, 1, 3'b010, 0, 2'h0);
    stall = 1'b0;
    tick();
    chk_all("st.r_ex", 1, 4'b1100, 0, 0, 3'h0, 1, 2'b11);
    drv_idle(); tick();
    chk_all("st.r_mem", 0, 4'h0, 0, 1, 3'b000, 0, 2'h0);
    tick();
    chk_all("st.r_wb", 0, 4'h0, 0, 0, 3'h0, 1, 2'b10);

    // 5: BEQ, R, R; flush while BEQ sits in MEM
    drv_beq(); tick();
    chk_all("fl.beq_ex", 1, 4'b0010, 0, 0, 3'h0, 0, 2'h0);
    drv_r(); tick();
    chk_all("fl.beq_mem", 1, 4'b1100, 0, 1, 3'b100, 0, 2'h0);
    flush = 1'b1; tick();
    chk_all("fl.flush", 0, 4'h0, 0, 0, 3'h0, 1, 2'b00);
    flush = 1'b0; drv_idle(); tick();
    chk_all("fl.after", 0, 4'h0, 0, 0, 3'h0, 0, 2'h0);

    // 6: stall and flush together behave as flush
    drv_beq(); tick();
    drv_r();   tick();
    flush = 1'b1; stall = 1'b1; tick();
    chk_all("sf.flush", 0, 4'h0, 0, 0, 3'h0, 1, 2'b00);
    flush = 1'b0; stall = 1'b0; drv_idle(); tick();
    chk_all("sf.after", 0, 4'h0, 0, 0, 3'h0, 0, 2'h0);

    // Mid-stream reset discards everything in flight
    drv_lw(); tick();
    drv_r();  tick();
    chk_all("mr.pre", 1, 4'b1100, 0, 1, 3'b010, 0, 2'h0);
    resetN = 1'b0; tick();
    chk_all("mr.reset", 0, 4'h0, 0, 0, 3'h0, 0, 2'h0);
    chk("mr.illegalSeen", 8'(illegalSeen), 8'h0);
    resetN = 1'b1; drv_idle(); tick();
    chk_all("mr.after", 0, 4'h0, 0, 0, 3'h0, 0, 2'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
